// File: rtl/btn_pkg.sv
// btn_pkg -- shared definitions for the pushbutton debounce controller.
//
// Contents:
//   btn_state_t           one-hot channel state encoding (five states)
//   DEFAULT_*             default channel count and cycle constants
//   max3()                helper used to size the shared channel counter
package btn_pkg;

  // One-hot encoding: exactly one bit set per state.
  typedef enum logic [4:0] {
    IDLE        = 5'b00001,
    DEB_PRESS   = 5'b00010,
    HOLD        = 5'b00100,
    REPEAT      = 5'b01000,
    DEB_RELEASE = 5'b10000
  } btn_state_t;

  localparam int DEFAULT_N_BTN           = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_HOLD_CYCLES     = 50_000_000;
  localparam int DEFAULT_REPEAT_CYCLES   = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel -- one pushbutton channel: optional input synchronizer, a
// press/hold/repeat/release FSM and the single counter it shares between
// phases.  Every cycle parameter must be at least 2.
//
// Ports:
//   clk      system clock
//   Reset    asynchronous, active-high reset
//   btn_raw  raw button level, 1 = pressed
//   dpb      debounced level
//   scen     one-cycle pulse per accepted press
//   mcen     pulse on press, then every REPEAT_CYCLES while repeating
//   ccen     high on every cycle of the repeat phase
//
// Configuration macro:
//   BTN_SYNC_EN  defined   -> btn_raw passes through a two-flop synchronizer
//                undefined -> btn_raw is used directly (already synchronous)
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic s;

`ifdef BTN_SYNC_EN
  logic sync_meta;
  logic sync_out;

  // Two-flop synchronizer; s lags btn_raw by two cycles.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = btn_raw;
`endif

  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             dpb_next, scen_next, mcen_next, ccen_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // The counter means: consecutive stable samples in DEB_PRESS/DEB_RELEASE,
  // HOLD cycles elapsed in HOLD, cycles since the last MCEN in REPEAT.
  // Outputs are computed from the next state so that, once registered,
  // they line up with the state register in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = DEB_PRESS;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= DEB_LAST) begin
          state_next = HOLD;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = sat_inc(cnt);
        end
      end
      HOLD: begin
        if (!s) begin
          state_next = DEB_RELEASE;
          cnt_next   = CNT_ONE;
        end else if (cnt >= HLD_LAST) begin
          state_next = REPEAT;
          cnt_next   = '0;
        end else begin
          cnt_next   = sat_inc(cnt);
        end
      end
      REPEAT: begin
        if (!s) begin
          state_next = DEB_RELEASE;
          cnt_next   = CNT_ONE;
        end else if (cnt >= REP_LAST) begin
          cnt_next   = '0;
        end else begin
          cnt_next   = sat_inc(cnt);
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          // Bounce back to pressed: restart the hold phase, no new press.
          state_next = HOLD;
          cnt_next   = CNT_ONE;
        end else if (cnt >= DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next   = sat_inc(cnt);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    scen_next = (state == DEB_PRESS) && (state_next == HOLD);
    ccen_next = (state_next == REPEAT);
    mcen_next = scen_next || (ccen_next && (cnt_next == '0));
    dpb_next  = (state_next == HOLD) || (state_next == REPEAT) ||
                (state_next == DEB_RELEASE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      dpb   <= 1'b0;
      scen  <= 1'b0;
      mcen  <= 1'b0;
      ccen  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dpb   <= dpb_next;
      scen  <= scen_next;
      mcen  <= mcen_next;
      ccen  <= ccen_next;
    end
  end

endmodule

// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl -- N_BTN independent pushbutton debouncers with
// press pulse, auto-repeat pulse and continuous repeat-phase enable.
//
// Ports:
//   clk      system clock
//   Reset    asynchronous, active-high reset
//   btn_raw  [N_BTN] raw button levels, 1 = pressed
//   DPB      [N_BTN] debounced levels
//   SCEN     [N_BTN] single-cycle pulse per accepted press
//   MCEN     [N_BTN] press pulse followed by auto-repeat pulses
//   CCEN     [N_BTN] high throughout the repeat phase
//
// Configuration macro:
//   BTN_SYNC_EN  enables a two-flop input synchronizer in every channel
module btn_debounce_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN           = DEFAULT_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] DPB,
  output logic [N_BTN-1:0] SCEN,
  output logic [N_BTN-1:0] MCEN,
  output logic [N_BTN-1:0] CCEN
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk     (clk),
      .Reset   (Reset),
      .btn_raw (btn_raw[i]),
      .dpb     (DPB[i]),
      .scen    (SCEN[i]),
      .mcen    (MCEN[i]),
      .ccen    (CCEN[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// tb_btn_debounce_ctrl -- self-checking bench for btn_debounce_ctrl.
// Works with or without BTN_SYNC_EN; directed cycle numbers are written
// for the synchronized build and shifted for the unsynchronized one.
module tb_btn_debounce_ctrl;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int HOLDC = 10;
  localparam int REP   = 3;
`ifdef BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int SHIFT = 2 - SYNC_LAT;

  logic         clk = 1'b0;
  logic         Reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] DPB, SCEN, MCEN, CCEN;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  btn_debounce_ctrl #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLDC),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk     (clk),
    .Reset   (Reset),
    .btn_raw (btn_raw),
    .DPB     (DPB),
    .SCEN    (SCEN),
    .MCEN    (MCEN),
    .CCEN    (CCEN)
  );

  // Behavioural reference: run lengths of the sampled level plus the age
  // of the current press, evaluated with plain arithmetic.
  logic [N-1:0] pipe0, pipe1;
  int           high_run [N];
  int           low_run  [N];
  int           age      [N];
  bit           pressed  [N];
  bit           fresh    [N];

  task automatic model_reset();
    pipe0 = '0;
    pipe1 = '0;
    for (int i = 0; i < N; i++) begin
      high_run[i] = 0;
      low_run[i]  = 0;
      age[i]      = 0;
      pressed[i]  = 1'b0;
      fresh[i]    = 1'b0;
    end
  endtask

  task automatic model_update(input logic [N-1:0] raw);
    logic [N-1:0] s;
    s     = (SYNC_LAT == 0) ? raw : pipe1;
    pipe1 = pipe0;
    pipe0 = raw;
    for (int i = 0; i < N; i++) begin
      fresh[i] = 1'b0;
      if (!pressed[i]) begin
        if (s[i]) begin
          high_run[i]++;
          if (high_run[i] == DEB) begin
            pressed[i]  = 1'b1;
            fresh[i]    = 1'b1;
            age[i]      = 1;
            high_run[i] = 0;
            low_run[i]  = 0;
          end
        end else begin
          high_run[i] = 0;
        end
      end else if (low_run[i] > 0) begin
        if (s[i]) begin
          low_run[i] = 0;
          age[i]     = 1;
        end else begin
          low_run[i]++;
          if (low_run[i] == DEB) begin
            pressed[i]  = 1'b0;
            low_run[i]  = 0;
            high_run[i] = 0;
          end
        end
      end else begin
        if (s[i]) age[i]++;
        else      low_run[i] = 1;
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Compare all outputs against the reference model for the current cycle.
  task automatic checkOutput();
    logic [N-1:0] e_dpb, e_scen, e_mcen, e_ccen;
    bit rep;
    for (int i = 0; i < N; i++) begin
      rep       = pressed[i] && (low_run[i] == 0) && (age[i] > HOLDC);
      e_dpb[i]  = pressed[i];
      e_scen[i] = fresh[i];
      e_ccen[i] = rep;
      e_mcen[i] = fresh[i] || (rep && (((age[i] - HOLDC - 1) % REP) == 0));
    end
    check_eq("model_dpb",  8'(DPB),  8'(e_dpb));
    check_eq("model_scen", 8'(SCEN), 8'(e_scen));
    check_eq("model_mcen", 8'(MCEN), 8'(e_mcen));
    check_eq("model_ccen", 8'(CCEN), 8'(e_ccen));
  endtask

  // Drive one cycle's inputs shortly after the clock edge and let them settle.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] raw);
    Reset   = rst;
    btn_raw = raw;
    if (rst) model_reset();
    #1;
  endtask

  task automatic advance(input logic rst, input logic [N-1:0] raw);
    @(posedge clk);
    if (!rst) model_update(raw);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, '0);
      checkOutput();
      advance(1'b1, '0);
    end
    cyc = 0;
  endtask

  typedef struct {
    int cyc;
    bit scen;
    bit mcen;
    bit ccen;
    bit dpb;
  } vec_t;

  vec_t hold_vecs [14];

  initial begin
    logic [N-1:0] raw;
    logic [N-1:0] seen;
    logic         rst;

    // Expected channel-0 outputs for a press at cycle 0 and release at 40.
    hold_vecs[0]  = '{5,  1'b0, 1'b0, 1'b0, 1'b0};
    hold_vecs[1]  = '{6,  1'b1, 1'b1, 1'b0, 1'b1};
    hold_vecs[2]  = '{7,  1'b0, 1'b0, 1'b0, 1'b1};
    hold_vecs[3]  = '{15, 1'b0, 1'b0, 1'b0, 1'b1};
    hold_vecs[4]  = '{16, 1'b0, 1'b1, 1'b1, 1'b1};
    hold_vecs[5]  = '{17, 1'b0, 1'b0, 1'b1, 1'b1};
    hold_vecs[6]  = '{18, 1'b0, 1'b0, 1'b1, 1'b1};
    hold_vecs[7]  = '{19, 1'b0, 1'b1, 1'b1, 1'b1};
    hold_vecs[8]  = '{22, 1'b0, 1'b1, 1'b1, 1'b1};
    hold_vecs[9]  = '{40, 1'b0, 1'b1, 1'b1, 1'b1};
    hold_vecs[10] = '{42, 1'b0, 1'b0, 1'b1, 1'b1};
    hold_vecs[11] = '{43, 1'b0, 1'b0, 1'b0, 1'b1};
    hold_vecs[12] = '{45, 1'b0, 1'b0, 1'b0, 1'b1};
    hold_vecs[13] = '{46, 1'b0, 1'b0, 1'b0, 1'b0};

    Reset   = 1'b1;
    btn_raw = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("reset_dpb",  8'(DPB),  8'h00);
    check_eq("reset_scen", 8'(SCEN), 8'h00);
    check_eq("reset_mcen", 8'(MCEN), 8'h00);
    check_eq("reset_ccen", 8'(CCEN), 8'h00);

    // Press, hold into repeat, release.
    $display("[TB] hold/repeat/release sequence");
    do_reset(2);
    for (int c = 0; c <= 55; c++) begin
      raw = (c < 40) ? 4'b0001 : 4'b0000;
      applyStimulus(1'b0, raw);
      checkOutput();
      for (int v = 0; v < 14; v++) begin
        if (hold_vecs[v].cyc - SHIFT == c)
          check_eq("hold_vec", {4'b0, SCEN[0], MCEN[0], CCEN[0], DPB[0]},
                   {4'b0, hold_vecs[v].scen, hold_vecs[v].mcen,
                    hold_vecs[v].ccen, hold_vecs[v].dpb});
      end
      advance(1'b0, raw);
    end

    // Bouncing input never stable long enough.
    $display("[TB] bounce sequence");
    do_reset(2);
    seen = '0;
    for (int c = 0; c < 40; c++) begin
      raw = {3'b000, (c % 4) != 3};
      applyStimulus(1'b0, raw);
      checkOutput();
      seen = seen | SCEN | MCEN | CCEN | DPB;
      advance(1'b0, raw);
    end
    check_eq("bounce_quiet", 8'(seen), 8'h00);

    // Simultaneous presses on channels 0 and 2.
    $display("[TB] dual press sequence");
    do_reset(2);
    for (int c = 0; c <= 12; c++) begin
      applyStimulus(1'b0, 4'b0101);
      checkOutput();
      if (c == 5 - SHIFT) check_eq("dual_pre",  8'(SCEN), 8'h00);
      if (c == 6 - SHIFT) check_eq("dual_scen", 8'(SCEN), 8'h05);
      if (c == 6 - SHIFT) check_eq("dual_mcen", 8'(MCEN), 8'h05);
      advance(1'b0, 4'b0101);
    end

    // Reset pulse while a button is held; the held button re-arms.
    $display("[TB] mid-press reset sequence");
    do_reset(2);
    for (int c = 0; c <= 40; c++) begin
      rst = (c >= 20) && (c <= 24);
      applyStimulus(rst, 4'b0001);
      checkOutput();
      if (c == 19) check_eq("pre_reset_dpb", 8'(DPB), 8'h01);
      if (c == 20) check_eq("reset_clear", 8'(DPB | SCEN | MCEN | CCEN), 8'h00);
      if (c == 30 - SHIFT) check_eq("rearm_early", 8'(SCEN), 8'h00);
      if (c == 31 - SHIFT) check_eq("rearm_scen",  8'(SCEN), 8'h01);
      advance(rst, 4'b0001);
    end

    // Randomized traffic: slow and bouncy channels, occasional reset.
    $display("[TB] random sequence");
    do_reset(2);
    raw = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i < 2) begin
          if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
        end else begin
          if ($urandom_range(0, 3) == 0) raw[i] = ~raw[i];
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus(rst, raw);
      checkOutput();
      advance(rst, raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
